// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared constants, index-width helper and read-tag type for the SRAM arbiter.
package sram_arb_pkg;

    localparam int DEF_NUM_REQ      = 2;
    localparam int DEF_DATA_WIDTH   = 4;
    localparam int DEF_ADDR_WIDTH   = 6;
    localparam int DEF_WMASK_WIDTH  = 2;
    localparam int DEF_READ_LATENCY = 2;
    localparam int ID_W             = 8;

    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

endpackage

// File: rtl/rr_grant.sv
// rr_grant: one-hot round-robin grant searching upward from ptr with wrap-around.
module rr_grant #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    // Walk from farthest to nearest so the requester closest to ptr is written last and wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (en && req[(int'(ptr) + k) % N]) begin
                gnt     = N'(1) << ((int'(ptr) + k) % N);
                gnt_idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin sharing of one SRAM wrapper among requesters,
// steering read data back to the issuing requester.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int WMASK_WIDTH  = DEF_WMASK_WIDTH,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*WMASK_WIDTH-1:0] req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_din,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           sram_we,
    output logic [WMASK_WIDTH-1:0]         sram_wmask,
    output logic [ADDR_WIDTH-1:0]          sram_addr,
    output logic [DATA_WIDTH-1:0]          sram_din,
    input  logic [DATA_WIDTH-1:0]          sram_dout,
    output logic                           busy
);

    localparam int IW = idx_w(NUM_REQ);

    logic [IW-1:0]      ptr_q, ptr_d, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic               accept;
    rd_tag_t            pipe_q [READ_LATENCY+1];
    rd_tag_t            pipe_d [READ_LATENCY+1];
    rd_tag_t            last;

    rr_grant #(.N(NUM_REQ), .IW(IW)) u_grant (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (!reset),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready  = gnt;
    assign accept     = |gnt;
    assign ptr_d      = !accept ? ptr_q : (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    assign sram_we    = accept & req_we[gnt_idx];
    assign sram_wmask = accept ? req_wmask[int'(gnt_idx)*WMASK_WIDTH +: WMASK_WIDTH] : '0;
    assign sram_addr  = accept ? req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign sram_din   = accept ? req_din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;

    // The wrapper registers its inputs on the accept edge, so the tag needs one stage beyond READ_LATENCY to line up with dout.
    always_comb begin
        pipe_d[0].valid = accept && !req_we[gnt_idx];
        pipe_d[0].id    = ID_W'(gnt_idx);
        for (int s = 1; s <= READ_LATENCY; s++) pipe_d[s] = pipe_q[s-1];
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s <= READ_LATENCY; s++) busy = busy | pipe_q[s].valid;
    end

    assign last      = pipe_q[READ_LATENCY];
    assign rsp_valid = last.valid ? NUM_REQ'(1) << last.id : '0;
    assign rsp_data  = last.valid ? sram_dout : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q  <= '0;
            pipe_q <= '{default: '0};
        end else begin
            ptr_q  <= ptr_d;
            pipe_q <= pipe_d;
        end
    end

endmodule
